// File: rtl/axi4s_frame_tx_if.sv
// Stream bundle for the frame transmitter: 96-bit pixel beats plus line/frame-end sideband.
interface axi4s_frame_tx_if #(
    parameter int DATA_W = 96
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              eol;
    logic              eof;

    modport master (output tdata, output tvalid, input tready, output eol, output eof);
    modport slave  (input tdata, input tvalid, output tready, input eol, input eof);
endinterface

// File: rtl/axi4s_frame_tx.sv
// Frame transmitter: streams BEATS_PER_LINE x LINES beats out of a 1-cycle-latency RAM
// through a 2-entry skid FIFO, with read issue throttled by FIFO credit.
module axi4s_frame_tx #(
    parameter int DATA_W         = 96,
    parameter int BEATS_PER_LINE = 160,
    parameter int LINES          = 480,
    parameter int ADDR_W         = $clog2(BEATS_PER_LINE * LINES)
) (
    input  logic              clock,
    input  logic              i_rst,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [DATA_W-1:0] i_rd_data,
    axi4s_frame_tx_if.master  m_axis
);
    localparam int BEAT_W = (BEATS_PER_LINE > 1) ? $clog2(BEATS_PER_LINE) : 1;
    localparam int LINE_W = (LINES > 1) ? $clog2(LINES) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS_PER_LINE - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(LINES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(BEATS_PER_LINE * LINES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic              w_rd_en;

    logic [BEAT_W-1:0] r_beat;
    logic [LINE_W-1:0] r_line;
    logic [ADDR_W-1:0] r_addr;
    logic              r_inflight;
    logic              r_infl_eol;
    logic              r_infl_eof;

    logic [DATA_W-1:0] r_fifo_data [2];
    logic [1:0]        r_fifo_eol;
    logic [1:0]        r_fifo_eof;
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_count;

    logic              w_valid;
    logic              w_pop;
    logic              w_push;
    logic [2:0]        w_credit;
    logic              w_eol;
    logic              w_eof;

    // Occupancy the FIFO will have after this edge if no new read is issued.
    assign w_valid  = (r_count != 2'd0);
    assign w_pop    = w_valid && m_axis.tready;
    assign w_push   = r_inflight;
    assign w_credit = 3'(r_count) + 3'(r_inflight) - 3'(w_pop);
    assign w_eol    = (r_beat == BEAT_LAST);
    assign w_eof    = w_eol && (r_line == LINE_LAST);

    // State register and registered done pulse.
    always_ff @(posedge clock or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state, read strobe and done decode.
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        w_rd_en     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_rd_en = (w_credit < 3'd2);
                if (w_rd_en && (r_addr == ADDR_LAST)) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                // Zero credit implies nothing in flight and the FIFO empties at this edge.
                if (w_credit == 3'd0) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Frame position counters and the sideband of the read currently in flight.
    always_ff @(posedge clock or posedge i_rst) begin
        if (i_rst) begin
            r_beat     <= '0;
            r_line     <= '0;
            r_addr     <= '0;
            r_inflight <= 1'b0;
            r_infl_eol <= 1'b0;
            r_infl_eof <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            if (r_state == S_IDLE) begin
                r_beat <= '0;
                r_line <= '0;
                r_addr <= '0;
            end else if (w_rd_en) begin
                r_infl_eol <= w_eol;
                r_infl_eof <= w_eof;
                r_addr     <= r_addr + ADDR_W'(1);
                if (w_eol) begin
                    r_beat <= '0;
                    r_line <= r_line + LINE_W'(1);
                end else begin
                    r_beat <= r_beat + BEAT_W'(1);
                end
            end
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clock or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) r_wptr <= ~r_wptr;
            if (w_pop)  r_rptr <= ~r_rptr;
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
        end
    end

    // FIFO storage; contents are only visible while the head entry is valid.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_data[r_wptr] <= i_rd_data;
            r_fifo_eol[r_wptr]  <= r_infl_eol;
            r_fifo_eof[r_wptr]  <= r_infl_eof;
        end
    end

    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = r_done;
    assign o_rd_en       = w_rd_en;
    assign o_rd_addr     = r_addr;
    assign m_axis.tvalid = w_valid;
    assign m_axis.tdata  = w_valid ? r_fifo_data[r_rptr] : '0;
    assign m_axis.eol    = w_valid ? r_fifo_eol[r_rptr] : 1'b0;
    assign m_axis.eof    = w_valid ? r_fifo_eof[r_rptr] : 1'b0;
endmodule
